l1_buyruk_onbellegi: RTL and testbench
======================================

// Module: l1_buyruk_onbellegi
// PURPOSE
//  Direct-mapped, read-only L1 instruction cache feeding the fetch (getir) stage.
//  Accepts word-aligned PCs from getir and returns 32-bit instruction words.
//  On a miss it stalls getir, burst-refills one line from the memory bus, then replies.
//  Sits between getir (downstream) and the memory/bus interface (upstream).
// PARAMETERS
//  SATIR_SAYISI  64  number of cache lines (power of 2)
//  SATIR_KELIME  4   32-bit words per line (power of 2, >=2)
//  ADRES_BIT     32  address width; ETIKET = ADRES_BIT-log2(SATIR_SAYISI)-log2(SATIR_KELIME)-2
// PORTS
//  clk_i                     in   1   clock
//  rst_i                     in   1   asynchronous reset, active-high
//  getir_ps_i                in   32  requested PC; bits [1:0] ignored
//  getir_ps_gecerli_i        in   1   request valid
//  getir_hazir_o             out  1   cache can accept a request this cycle
//  getir_oku_adres_kabul_o   out  1   request accepted (getir_ps_gecerli_i & getir_hazir_o)
//  getir_buy_o               out  32  instruction word
//  getir_gecerli_o           out  1   getir_buy_o valid (1-cycle pulse per request)
//  getir_duraklat_o          out  1   miss in progress; getir must hold
//  ddb_temizle_i             in   1   invalidate all lines (fence.i)
//  bellek_adres_o            out  32  refill line base address (offset bits zero)
//  bellek_istek_gecerli_o    out  1   refill request valid
//  bellek_istek_hazir_i      in   1   bus accepts request
//  bellek_veri_i             in   32  refill data beat
//  bellek_veri_gecerli_i     in   1   refill beat valid (beats in ascending word order)
// BEHAVIOUR
//  Reset: all valid bits 0, FSM=BOSTA, stored request and fill buffer 0.
//   Outputs: getir_gecerli_o=0, getir_buy_o=0, getir_duraklat_o=0, getir_hazir_o=1,
//   bellek_istek_gecerli_o=0, bellek_adres_o=0.
//  Storage: data and tag arrays have registered (1-cycle) read; valid bits are flops.
//  FSM states:
//   BOSTA: hazir=1. On accept: latch PC, read arrays, go to KARSILASTIR.
//   KARSILASTIR: compare tag and valid.
//    Hit: gecerli=1, buy=data word; hazir=1. Back-to-back accept stays in KARSILASTIR.
//     With no new request, go to BOSTA.
//    Miss: gecerli=0, hazir=0, duraklat=1; go to ISTEK.
//   ISTEK: istek_gecerli=1, adres={PC[31:off],0}; duraklat=1.
//    Hold both until bellek_istek_hazir_i, then go to DOLDUR with beat counter=0.
//   DOLDUR: duraklat=1. Each bellek_veri_gecerli_i writes fill buffer[sayac], sayac++.
//    On beat SATIR_KELIME-1: write line+tag, set valid, go to YANIT.
//   YANIT: gecerli=1, buy=fill word at PC offset, duraklat=0, hazir=0; go to BOSTA.
//  Latency: hit = 1 cycle after accept; fully pipelined at 1 req/cycle.
//   Miss = 1 + bus handshake + SATIR_KELIME beats + 1.
//  getir_hazir_o=0 in ISTEK, DOLDUR and YANIT. No request is accepted during a miss.
//  ddb_temizle_i: clears all valid bits next edge, any state.
//   In KARSILASTIR in the same cycle: the lookup uses the old valids (a hit still returns).
//   During ISTEK/DOLDUR: the bus transfer completes and the word is still returned in YANIT,
//    but the line is NOT marked valid. Flush wins over set on the final beat.
//  bellek_veri_gecerli_i outside DOLDUR is ignored.
//  Index = PC[off+idx-1:off]; offset = PC[off-1:2]; tag = upper bits.
//  Counter wraps at SATIR_KELIME. Reset asserted mid-refill aborts to BOSTA.
//   The bus side must tolerate the dropped transaction.
// CONFIGURATION
//  L1B_SAYAC_EN defined: adds outputs sayac_isabet_o[31:0] and sayac_iska_o[31:0].
//   sayac_isabet_o counts hits; sayac_iska_o counts misses. Both wrap at 2^32 and reset to 0.
//   ddb_temizle_i does not clear them.
//  Undefined: the ports and counters are absent; all other behaviour is identical.
// TESTING
//  1 Cold miss: req PC=0x100 after reset -> duraklat=1, bellek_adres_o=0x100, istek held.
//    4 beats 0xA0..0xA3 -> gecerli=1, buy=0xA0; miss latency 7 cycles with hazir_i=1 immediately.
//  2 Hit stream: then PC=0x104,0x108,0x10C on consecutive cycles -> buy=0xA1,0xA2,0xA3.
//    Each arrives 1 cycle after accept, with no duraklat.
//  3 Critical word: cold PC=0x20C -> bellek_adres_o=0x200; after 4 beats buy=beat3 value.
//  4 Conflict: PC=0x100 then PC=0x500 (same index, SATIR_SAYISI=64) -> both miss.
//    Re-request 0x100 -> misses again.
//  5 Flush: temizle_i during DOLDUR of 0x300 -> word returned.
//    Next req 0x300 misses; temizle_i in BOSTA then req 0x100 -> miss.
//  6 Reset mid-DOLDUR after 2 beats -> FSM BOSTA, hazir=1, all outputs at reset values.
//    With L1B_SAYAC_EN: after tests 1-2, isabet=3, iska=1.

Source files
------------

// File: rtl/l1_buyruk_onbellegi.sv
// l1_buyruk_onbellegi: direct-mapped read-only L1 instruction cache with burst line refill.
// Defining L1B_SAYAC_EN adds the hit/miss counter outputs.
module l1_buyruk_onbellegi #(
  parameter int SATIR_SAYISI = 64,
  parameter int SATIR_KELIME = 4,
  parameter int ADRES_BIT    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADRES_BIT-1:0] getir_ps_i,
  input  logic                 getir_ps_gecerli_i,
  output logic                 getir_hazir_o,
  output logic                 getir_oku_adres_kabul_o,
  output logic [31:0]          getir_buy_o,
  output logic                 getir_gecerli_o,
  output logic                 getir_duraklat_o,
  input  logic                 ddb_temizle_i,
  output logic [ADRES_BIT-1:0] bellek_adres_o,
  output logic                 bellek_istek_gecerli_o,
  input  logic                 bellek_istek_hazir_i,
  input  logic [31:0]          bellek_veri_i,
  input  logic                 bellek_veri_gecerli_i
`ifdef L1B_SAYAC_EN
  ,
  output logic [31:0]          sayac_isabet_o,
  output logic [31:0]          sayac_iska_o
`endif
);
  localparam int KB = $clog2(SATIR_KELIME);
  localparam int OB = KB + 2;
  localparam int IB = $clog2(SATIR_SAYISI);
  localparam int EB = ADRES_BIT - IB - OB;
  typedef enum logic [2:0] {BOSTA, KARSILASTIR, ISTEK, DOLDUR, YANIT} durum_e;
  durum_e durum_q, durum_d;
  logic [ADRES_BIT-1:0] ps_q;
  logic [KB-1:0] sayac_q;
  logic [SATIR_KELIME-1:0][31:0] tampon_q, satir_oku_q, yeni_satir;
  logic [SATIR_SAYISI-1:0] gecerli_q;
  logic iptal_q;
  logic [SATIR_KELIME-1:0][31:0] veri_dizi [SATIR_SAYISI];
  logic [EB-1:0] etiket_dizi [SATIR_SAYISI];
  logic [EB-1:0] etiket_oku_q;
  logic [IB-1:0] idx_q;
  logic [KB-1:0] ofs_q;
  logic [EB-1:0] etk_q;
  logic isabet, kabul, vurus, son;
  assign idx_q = ps_q[OB+IB-1:OB];
  assign ofs_q = ps_q[OB-1:2];
  assign etk_q = ps_q[ADRES_BIT-1:OB+IB];
  assign isabet = gecerli_q[idx_q] && etiket_oku_q == etk_q;
  assign kabul = getir_ps_gecerli_i && getir_hazir_o;
  assign getir_oku_adres_kabul_o = kabul;
  assign vurus = durum_q == DOLDUR && bellek_veri_gecerli_i;
  assign son = vurus && sayac_q == KB'(SATIR_KELIME - 1);
  always_comb begin
    yeni_satir = tampon_q;
    yeni_satir[sayac_q] = bellek_veri_i;
  end
  always_comb begin
    durum_d = durum_q;
    getir_hazir_o = 1'b0;
    getir_gecerli_o = 1'b0;
    getir_buy_o = '0;
    getir_duraklat_o = 1'b0;
    bellek_istek_gecerli_o = 1'b0;
    bellek_adres_o = '0;
    unique case (durum_q)
      BOSTA: begin
        getir_hazir_o = 1'b1;
        durum_d = getir_ps_gecerli_i ? KARSILASTIR : BOSTA;
      end
      KARSILASTIR: begin
        getir_hazir_o = isabet;
        getir_gecerli_o = isabet;
        getir_buy_o = isabet ? satir_oku_q[ofs_q] : '0;
        getir_duraklat_o = !isabet;
        durum_d = !isabet ? ISTEK : getir_ps_gecerli_i ? KARSILASTIR : BOSTA;
      end
      ISTEK: begin
        getir_duraklat_o = 1'b1;
        bellek_istek_gecerli_o = 1'b1;
        bellek_adres_o = {ps_q[ADRES_BIT-1:OB], {OB{1'b0}}};
        durum_d = bellek_istek_hazir_i ? DOLDUR : ISTEK;
      end
      DOLDUR: begin
        getir_duraklat_o = 1'b1;
        durum_d = son ? YANIT : DOLDUR;
      end
      YANIT: begin
        getir_gecerli_o = 1'b1;
        getir_buy_o = tampon_q[ofs_q];
        durum_d = BOSTA;
      end
      default: durum_d = BOSTA;
    endcase
  end
  // A flush seen while the refill is in flight keeps the arriving line invalid.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      durum_q <= BOSTA;
      ps_q <= '0;
      sayac_q <= '0;
      tampon_q <= '0;
      gecerli_q <= '0;
      iptal_q <= 1'b0;
    end else begin
      durum_q <= durum_d;
      if (kabul) ps_q <= getir_ps_i;
      sayac_q <= (durum_q == ISTEK) ? '0 : vurus ? sayac_q + 1'b1 : sayac_q;
      if (vurus) tampon_q[sayac_q] <= bellek_veri_i;
      iptal_q <= (durum_q == ISTEK || durum_q == DOLDUR) && (iptal_q || ddb_temizle_i);
      if (ddb_temizle_i) gecerli_q <= '0;
      else if (son && !iptal_q) gecerli_q[idx_q] <= 1'b1;
    end
  always_ff @(posedge clk_i) begin
    if (son) begin
      veri_dizi[idx_q] <= yeni_satir;
      etiket_dizi[idx_q] <= etk_q;
    end
    if (kabul) begin
      satir_oku_q <= veri_dizi[getir_ps_i[OB+IB-1:OB]];
      etiket_oku_q <= etiket_dizi[getir_ps_i[OB+IB-1:OB]];
    end
  end
`ifdef L1B_SAYAC_EN
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      sayac_isabet_o <= '0;
      sayac_iska_o <= '0;
    end else if (durum_q == KARSILASTIR) begin
      if (isabet) sayac_isabet_o <= sayac_isabet_o + 32'd1;
      else sayac_iska_o <= sayac_iska_o + 32'd1;
    end
`endif
endmodule

// File: tb/tb_l1_buyruk_onbellegi.sv
// tb_l1_buyruk_onbellegi: randomized bench for the L1 instruction cache against a line-level model.
module tb_l1_buyruk_onbellegi;
  localparam int S = 64;
  localparam int K = 4;
  logic clk_i = 1'b0;
  logic rst_i;
  logic [31:0] getir_ps_i;
  logic getir_ps_gecerli_i, getir_hazir_o, getir_oku_adres_kabul_o;
  logic [31:0] getir_buy_o;
  logic getir_gecerli_o, getir_duraklat_o, ddb_temizle_i;
  logic [31:0] bellek_adres_o;
  logic bellek_istek_gecerli_o, bellek_istek_hazir_i;
  logic [31:0] bellek_veri_i;
  logic bellek_veri_gecerli_i;
`ifdef L1B_SAYAC_EN
  logic [31:0] sayac_isabet_o, sayac_iska_o;
`endif
  l1_buyruk_onbellegi dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .getir_ps_i(getir_ps_i), .getir_ps_gecerli_i(getir_ps_gecerli_i),
    .getir_hazir_o(getir_hazir_o), .getir_oku_adres_kabul_o(getir_oku_adres_kabul_o),
    .getir_buy_o(getir_buy_o), .getir_gecerli_o(getir_gecerli_o),
    .getir_duraklat_o(getir_duraklat_o), .ddb_temizle_i(ddb_temizle_i),
    .bellek_adres_o(bellek_adres_o), .bellek_istek_gecerli_o(bellek_istek_gecerli_o),
    .bellek_istek_hazir_i(bellek_istek_hazir_i), .bellek_veri_i(bellek_veri_i),
    .bellek_veri_gecerli_i(bellek_veri_gecerli_i)
`ifdef L1B_SAYAC_EN
    , .sayac_isabet_o(sayac_isabet_o), .sayac_iska_o(sayac_iska_o)
`endif
  );
  always #5 clk_i = ~clk_i;
  int vec = 0;
  int err = 0;
  int m_isabet = 0;
  int m_iska = 0;
  logic [31:0] bellek [logic [31:0]];
  bit vld [S];
  logic [27:0] etk [S];
  logic [31:0] akis [$];
  function automatic logic [31:0] rd(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return bellek.exists(w) ? bellek[w] : (w * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction
  function automatic bit model_hit(input logic [31:0] pc);
    return vld[pc[9:4]] && etk[pc[9:4]] == pc[31:4];
  endfunction
  task automatic model_flush();
    foreach (vld[i]) vld[i] = 1'b0;
  endtask
  task automatic check_idle(input string nm);
    vec++;
    if ({getir_gecerli_o, getir_duraklat_o, getir_hazir_o, bellek_istek_gecerli_o} !== 4'b0010 ||
        getir_buy_o !== 32'h0 || bellek_adres_o !== 32'h0) begin
      err++;
      $display("FAIL %s: gec=%b dur=%b hz=%b ist=%b buy=%h adr=%h, need 0 0 1 0 0 0", nm,
               getir_gecerli_o, getir_duraklat_o, getir_hazir_o, bellek_istek_gecerli_o, getir_buy_o, bellek_adres_o);
    end
  endtask
  // One request from an idle/hit state; the bus model answers a miss with
  // hs_wait stalled handshake cycles and optional gaps between beats.
  task automatic do_req(input logic [31:0] pc, input int hs_wait, input int flush_beat,
                        input bit kars_flush, input bit gaps);
    logic [31:0] base, w;
    bit h;
    base = {pc[31:4], 4'h0};
    w = rd(pc);
    h = model_hit(pc);
    getir_ps_i = pc;
    getir_ps_gecerli_i = 1'b1;
    #1;
    vec++;
    if (getir_oku_adres_kabul_o !== 1'b1) begin
      err++;
      $display("FAIL accept pc=%h: kabul=%b need 1", pc, getir_oku_adres_kabul_o);
    end
    @(negedge clk_i);
    getir_ps_gecerli_i = 1'b0;
    ddb_temizle_i = kars_flush;
    if (h) begin
      m_isabet++;
      vec++;
      if ({getir_gecerli_o, getir_duraklat_o, getir_hazir_o} !== 3'b101 || getir_buy_o !== w) begin
        err++;
        $display("FAIL hit pc=%h: gec=%b dur=%b hz=%b buy=%h, need 1 0 1 %h", pc,
                 getir_gecerli_o, getir_duraklat_o, getir_hazir_o, getir_buy_o, w);
      end
      if (kars_flush) model_flush();
      @(negedge clk_i);
      ddb_temizle_i = 1'b0;
      return;
    end
    m_iska++;
    vec++;
    if ({getir_gecerli_o, getir_duraklat_o, getir_hazir_o} !== 3'b010) begin
      err++;
      $display("FAIL miss_detect pc=%h: gec=%b dur=%b hz=%b, need 0 1 0", pc,
               getir_gecerli_o, getir_duraklat_o, getir_hazir_o);
    end
    if (kars_flush) model_flush();
    @(negedge clk_i);
    ddb_temizle_i = 1'b0;
    for (int i = 0; i <= hs_wait; i++) begin
      bellek_veri_gecerli_i = (i < hs_wait);
      bellek_veri_i = $urandom;
      vec++;
      if ({bellek_istek_gecerli_o, getir_duraklat_o, getir_hazir_o, getir_gecerli_o} !== 4'b1100 ||
          bellek_adres_o !== base) begin
        err++;
        $display("FAIL request pc=%h cyc=%0d: ist=%b dur=%b hz=%b gec=%b adr=%h, need 1 1 0 0 %h", pc, i,
                 bellek_istek_gecerli_o, getir_duraklat_o, getir_hazir_o, getir_gecerli_o, bellek_adres_o, base);
      end
      bellek_istek_hazir_i = (i == hs_wait);
      @(negedge clk_i);
    end
    bellek_istek_hazir_i = 1'b0;
    bellek_veri_gecerli_i = 1'b0;
    for (int b = 0; b < K; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bellek_veri_i = $urandom;
        @(negedge clk_i);
      end
      vec++;
      if ({bellek_istek_gecerli_o, getir_duraklat_o, getir_hazir_o, getir_gecerli_o} !== 4'b0100) begin
        err++;
        $display("FAIL fill pc=%h beat=%0d: ist=%b dur=%b hz=%b gec=%b, need 0 1 0 0", pc, b,
                 bellek_istek_gecerli_o, getir_duraklat_o, getir_hazir_o, getir_gecerli_o);
      end
      bellek_veri_i = rd(base + 32'(4 * b));
      bellek_veri_gecerli_i = 1'b1;
      ddb_temizle_i = (b == flush_beat);
      @(negedge clk_i);
      bellek_veri_gecerli_i = 1'b0;
      ddb_temizle_i = 1'b0;
    end
    vec++;
    if ({getir_gecerli_o, getir_duraklat_o, getir_hazir_o} !== 3'b100 || getir_buy_o !== w) begin
      err++;
      $display("FAIL reply pc=%h: gec=%b dur=%b hz=%b buy=%h, need 1 0 0 %h", pc,
               getir_gecerli_o, getir_duraklat_o, getir_hazir_o, getir_buy_o, w);
    end
    if (flush_beat >= 0) model_flush();
    else begin
      vld[pc[9:4]] = 1'b1;
      etk[pc[9:4]] = pc[31:4];
    end
    @(negedge clk_i);
    check_idle("after_reply");
  endtask
  task automatic run_stream();
    for (int i = 0; i < akis.size(); i++) begin
      getir_ps_i = akis[i];
      getir_ps_gecerli_i = 1'b1;
      #1;
      vec++;
      if (getir_oku_adres_kabul_o !== 1'b1) begin
        err++;
        $display("FAIL stream_accept i=%0d: kabul=%b need 1", i, getir_oku_adres_kabul_o);
      end
      @(negedge clk_i);
      m_isabet++;
      vec++;
      if ({getir_gecerli_o, getir_duraklat_o} !== 2'b10 || getir_buy_o !== rd(akis[i])) begin
        err++;
        $display("FAIL stream pc=%h: gec=%b dur=%b buy=%h, need 1 0 %h", akis[i],
                 getir_gecerli_o, getir_duraklat_o, getir_buy_o, rd(akis[i]));
      end
    end
    getir_ps_gecerli_i = 1'b0;
    @(negedge clk_i);
    check_idle("stream_end");
  endtask
  task automatic flush_idle();
    ddb_temizle_i = 1'b1;
    @(negedge clk_i);
    ddb_temizle_i = 1'b0;
    model_flush();
  endtask
  task automatic test_reset();
    rst_i = 1'b1;
    getir_ps_i = '0;
    getir_ps_gecerli_i = 1'b0;
    ddb_temizle_i = 1'b0;
    bellek_istek_hazir_i = 1'b0;
    bellek_veri_i = '0;
    bellek_veri_gecerli_i = 1'b0;
    model_flush();
    @(negedge clk_i);
    check_idle("reset");
    rst_i = 1'b0;
  endtask
  task automatic test_cold_miss_and_stream();
    for (int i = 0; i < K; i++) bellek[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
    do_req(32'h100, 0, -1, 1'b0, 1'b0);
    akis = '{32'h104, 32'h108, 32'h10C};
    run_stream();
`ifdef L1B_SAYAC_EN
    vec++;
    if (sayac_isabet_o !== 32'd3 || sayac_iska_o !== 32'd1) begin
      err++;
      $display("FAIL counters_t12: isabet=%0d iska=%0d need 3 1", sayac_isabet_o, sayac_iska_o);
    end
`endif
  endtask
  task automatic test_critical_and_conflict();
    do_req(32'h20C, 0, -1, 1'b0, 1'b0);
    do_req(32'h500, 1, -1, 1'b0, 1'b0);
    do_req(32'h100, 0, -1, 1'b0, 1'b0);
    do_req(32'h104, 0, -1, 1'b0, 1'b0);
  endtask
  task automatic test_flush();
    do_req(32'h300, 0, 2, 1'b0, 1'b0);
    do_req(32'h300, 0, -1, 1'b0, 1'b0);
    do_req(32'h100, 0, -1, 1'b0, 1'b0);
    flush_idle();
    do_req(32'h100, 0, -1, 1'b0, 1'b0);
    do_req(32'h308, 0, -1, 1'b1, 1'b0);
    do_req(32'h304, 0, -1, 1'b0, 1'b0);
    do_req(32'h140, 0, K - 1, 1'b0, 1'b0);
    do_req(32'h144, 0, -1, 1'b0, 1'b0);
  endtask
  task automatic test_random();
    int sel;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) flush_idle();
      else if (sel <= 2) begin
        int vi [$];
        foreach (vld[i]) if (vld[i]) vi.push_back(i);
        akis = {};
        if (vi.size() > 0)
          for (int j = 0; j < $urandom_range(1, 8); j++)
            akis.push_back({etk[vi[$urandom_range(0, vi.size() - 1)]], 2'($urandom), 2'($urandom)});
        if (akis.size() > 0) run_stream();
      end else
        do_req($urandom_range(0, 32'h1FFF), $urandom_range(0, 3),
               ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, K - 1)) : -1,
               $urandom_range(0, 7) == 0, 1'b1);
    end
  endtask
  task automatic test_reset_mid_fill();
    logic [31:0] pc;
    pc = 32'h7A8;
    flush_idle();
    getir_ps_i = pc;
    getir_ps_gecerli_i = 1'b1;
    @(negedge clk_i);
    getir_ps_gecerli_i = 1'b0;
    @(negedge clk_i);
    bellek_istek_hazir_i = 1'b1;
    @(negedge clk_i);
    bellek_istek_hazir_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bellek_veri_i = rd({pc[31:4], 4'h0} + 32'(4 * b));
      bellek_veri_gecerli_i = 1'b1;
      @(negedge clk_i);
    end
    bellek_veri_gecerli_i = 1'b0;
    vec++;
    if (getir_duraklat_o !== 1'b1) begin
      err++;
      $display("FAIL pre_reset_stall: dur=%b need 1", getir_duraklat_o);
    end
    rst_i = 1'b1;
    #1;
    check_idle("async_reset");
    model_flush();
    m_isabet = 0;
    m_iska = 0;
    @(negedge clk_i);
    check_idle("reset_held");
    rst_i = 1'b0;
    do_req(pc, 0, -1, 1'b0, 1'b0);
    do_req(pc, 0, -1, 1'b0, 1'b0);
  endtask
  initial begin
    test_reset();
    test_cold_miss_and_stream();
    test_critical_and_conflict();
    test_flush();
    test_random();
    test_reset_mid_fill();
`ifdef L1B_SAYAC_EN
    vec++;
    if (sayac_isabet_o !== 32'(m_isabet) || sayac_iska_o !== 32'(m_iska)) begin
      err++;
      $display("FAIL counters_final: isabet=%0d iska=%0d need %0d %0d", sayac_isabet_o, sayac_iska_o, m_isabet, m_iska);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
